// File: rtl/mem_stage.sv
// MEM stage of the MIPS pipeline: word-addressed data memory with configurable
// wait states, branch resolution and the MEM/WB pipeline register.
module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctlin,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] add_result,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  write_reg,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [1:0]  wb_ctlout,
  output logic [31:0] mem_rdata,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    wb_q, wb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   alu_q, alu_d;
  logic [4:0]    wreg_q, wreg_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] addr;
  logic          op, is_load, done, stall_c;
  logic          unused_addr_bits;

  // Upper and byte-offset address bits are dropped, so accesses wrap modulo depth.
  assign addr             = alu_result[AW+1:2];
  assign unused_addr_bits = ^{alu_result[31:AW+2], alu_result[1:0]};
  assign op               = memread | memwrite;
  assign is_load          = memread & ~memwrite;

  assign pcsrc         = branch & zero;
  assign branch_target = add_result;
  assign stall         = stall_c;
  assign dbg_state     = (state_q == S_WAIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (WAIT_STATES == 0) begin
            done = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q > CNT_ONE) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stalled cycles emit a bubble; every other edge loads the instruction in MEM.
  always_comb begin
    wb_d    = wb_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    wreg_d  = wreg_q;
    if (stall_c) begin
      wb_d = '0;
    end else begin
      wb_d    = wb_ctlin;
      rdata_d = is_load ? mem[addr] : '0;
      alu_d   = alu_result;
      wreg_d  = write_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
    end
  end

  // Memory contents survive reset; a store commits only on its completing edge.
  always_ff @(posedge clk) begin
    if (done && memwrite) begin
      mem[addr] <= rdata2out;
    end
  end

  assign wb_ctlout      = wb_q;
  assign mem_rdata      = rdata_q;
  assign alu_result_out = alu_q;
  assign write_reg_out  = wreg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: one instance with single-cycle memory, one with two wait
// states, both checked against a transaction-level memory/pipeline model.
module tb_mem_stage;

  localparam int W0 = 0;
  localparam int W1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  in_wb     [2];
  logic        in_branch [2];
  logic        in_rd     [2];
  logic        in_wr     [2];
  logic        in_zero   [2];
  logic [31:0] in_add    [2];
  logic [31:0] in_alu    [2];
  logic [31:0] in_wdata  [2];
  logic [4:0]  in_wreg   [2];

  logic        o_pcsrc  [2];
  logic [31:0] o_target [2];
  logic        o_stall  [2];
  logic [1:0]  o_wb     [2];
  logic [31:0] o_rdata  [2];
  logic [31:0] o_alu    [2];
  logic [4:0]  o_wreg   [2];
  logic        o_dbg    [2];

  mem_stage #(.DEPTH_WORDS(256), .WAIT_STATES(W0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wb_ctlin(in_wb[0]), .branch(in_branch[0]),
    .memread(in_rd[0]), .memwrite(in_wr[0]), .zero(in_zero[0]),
    .add_result(in_add[0]), .alu_result(in_alu[0]), .rdata2out(in_wdata[0]),
    .write_reg(in_wreg[0]), .pcsrc(o_pcsrc[0]), .branch_target(o_target[0]),
    .stall(o_stall[0]), .wb_ctlout(o_wb[0]), .mem_rdata(o_rdata[0]),
    .alu_result_out(o_alu[0]), .write_reg_out(o_wreg[0]), .dbg_state(o_dbg[0])
  );

  mem_stage #(.DEPTH_WORDS(256), .WAIT_STATES(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wb_ctlin(in_wb[1]), .branch(in_branch[1]),
    .memread(in_rd[1]), .memwrite(in_wr[1]), .zero(in_zero[1]),
    .add_result(in_add[1]), .alu_result(in_alu[1]), .rdata2out(in_wdata[1]),
    .write_reg(in_wreg[1]), .pcsrc(o_pcsrc[1]), .branch_target(o_target[1]),
    .stall(o_stall[1]), .wb_ctlout(o_wb[1]), .mem_rdata(o_rdata[1]),
    .alu_result_out(o_alu[1]), .write_reg_out(o_wreg[1]), .dbg_state(o_dbg[1])
  );

  // Reference model: memory image per instance plus the last MEM/WB contents.
  logic [31:0] model_mem [2][256];
  logic [31:0] prev_rdata [2];
  logic [31:0] prev_alu   [2];
  logic [4:0]  prev_wreg  [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wait_of(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  task automatic idle_inputs(input int k);
    in_wb[k] = '0; in_branch[k] = 1'b0; in_rd[k] = 1'b0; in_wr[k] = 1'b0;
    in_zero[k] = 1'b0; in_add[k] = '0; in_alu[k] = '0; in_wdata[k] = '0;
    in_wreg[k] = '0;
  endtask

  // Reset asserted immediately, checked while low, released on a later falling edge.
  task automatic do_reset();
    idle_inputs(0);
    idle_inputs(1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_wb", 32'(o_wb[k]), 32'd0);
      check("rst_rdata", o_rdata[k], 32'd0);
      check("rst_alu", o_alu[k], 32'd0);
      check("rst_wreg", 32'(o_wreg[k]), 32'd0);
      check("rst_stall", 32'(o_stall[k]), 32'd0);
      check("rst_state", 32'(o_dbg[k]), 32'd0);
      prev_rdata[k] = '0; prev_alu[k] = '0; prev_wreg[k] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_op(input int k, input logic [1:0] wb, input logic br, input logic z,
                       input logic rd, input logic wr, input logic [31:0] add,
                       input logic [31:0] alu, input logic [31:0] wdata,
                       input logic [4:0] wreg);
    int nw;
    int idx;
    logic [31:0] exp_rd;
    nw     = (rd || wr) ? wait_of(k) : 0;
    idx    = int'(alu[9:2]);
    exp_rd = (rd && !wr) ? model_mem[k][idx] : 32'd0;
    for (int c = 0; c <= nw; c++) begin
      @(negedge clk);
      if (c == 0) begin
        in_wb[k] = wb; in_branch[k] = br; in_zero[k] = z; in_rd[k] = rd;
        in_wr[k] = wr; in_add[k] = add; in_alu[k] = alu; in_wdata[k] = wdata;
        in_wreg[k] = wreg;
      end
      #1;
      check("stall", 32'(o_stall[k]), (c < nw) ? 32'd1 : 32'd0);
      check("pcsrc", 32'(o_pcsrc[k]), 32'(br & z));
      check("target", o_target[k], add);
      @(posedge clk);
      #1;
      if (c < nw) begin
        check("bubble_wb", 32'(o_wb[k]), 32'd0);
        check("hold_alu", o_alu[k], prev_alu[k]);
        check("hold_wreg", 32'(o_wreg[k]), 32'(prev_wreg[k]));
        check("hold_rdata", o_rdata[k], prev_rdata[k]);
      end
    end
    check("wb", 32'(o_wb[k]), 32'(wb));
    check("rdata", o_rdata[k], exp_rd);
    check("alu", o_alu[k], alu);
    check("wreg", 32'(o_wreg[k]), 32'(wreg));
    if (wr) model_mem[k][idx] = wdata;
    prev_rdata[k] = exp_rd; prev_alu[k] = alu; prev_wreg[k] = wreg;
    prev_rdata[1-k] = '0; prev_alu[1-k] = '0; prev_wreg[1-k] = '0;
    idle_inputs(k);
  endtask

  task automatic store(input int k, input logic [31:0] a, input logic [31:0] d);
    do_op(k, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, a, d, 5'd0);
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [4:0] r);
    do_op(k, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, a, 32'd0, r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs(0);
    idle_inputs(1);
    do_reset();

    // Traffic, then reset mid-run, then the first post-reset instruction.
    do_op(0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_00AA, 32'd0, 5'd9);
    do_op(1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_00BB, 32'd0, 5'd3);
    do_reset();
    do_op(0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_1234, 32'd0, 5'd5);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) store(k, 32'(i * 4), $urandom);

    store(0, 32'h10, 32'hDEAD_BEEF);
    load(0, 32'h10, 5'd7);
    store(1, 32'h20, 32'hCAFE_F00D);
    load(1, 32'h20, 5'd8);

    do_op(0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, 32'd0, 5'd0);
    do_op(1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'd0, 32'd0, 5'd0);

    for (int k = 0; k < 2; k++) begin
      store(k, 32'h400, 32'h0BAD_F00D ^ 32'(k));
      load(k, 32'h0, 5'd1);
      do_op(k, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'h14, 32'h7777_0000 + 32'(k), 5'd2);
      load(k, 32'h14, 5'd2);
    end

    // Abort a store while the two-wait-state instance is in WAIT.
    store(1, 32'h8, 32'h1111_2222);
    @(negedge clk);
    in_wr[1] = 1'b1; in_alu[1] = 32'h8; in_wdata[1] = 32'h5555_AAAA;
    #1;
    check("abort_stall", 32'(o_stall[1]), 32'd1);
    @(posedge clk);
    #1;
    check("abort_in_wait", 32'(o_dbg[1]), 32'd1);
    do_reset();
    load(1, 32'h8, 5'd4);

    for (int i = 0; i < 150; i++) begin
      int k;
      int kind;
      int idx;
      logic [31:0] a;
      k    = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      idx  = $urandom_range(0, 15);
      a    = ($urandom & 32'hFFFF_FC03) | 32'(idx << 2);
      do_op(k, 2'($urandom), 1'($urandom), 1'($urandom), kind == 1 || kind == 3,
            kind == 2 || kind == 3, $urandom, (kind == 0) ? $urandom : a, $urandom,
            5'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
